// File: rtl/sfq_toggle_pulse_rx_pkg.sv
// rtl/sfq_toggle_pulse_rx_pkg.sv - shared types and default widths for the SFQ pulse receiver
package sfq_rx_pkg;
    localparam int TS_W_DEF  = 16;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        FAULT = 2'd2
    } rx_state_e;

    // Queue entries carry the widest timestamp; narrower receivers zero-extend.
    typedef struct packed {
        logic [TS_W_DEF-1:0] ts;
        logic                err;
    } rx_event_t;
endpackage

// File: rtl/sfq_toggle_pulse_rx_if.sv
// rtl/sfq_toggle_pulse_rx_if.sv - valid/ready event stream from the receiver to its consumer
interface sfq_toggle_pulse_rx_if #(
    parameter int TS_W = sfq_rx_pkg::TS_W_DEF
);
    logic            ev_valid;
    logic            ev_ready;
    logic [TS_W-1:0] ev_ts;
    logic            ev_err;

    modport master (output ev_valid, output ev_ts, output ev_err, input ev_ready);
    modport slave  (input ev_valid, input ev_ts, input ev_err, output ev_ready);
endinterface

// File: rtl/sfq_toggle_pulse_rx_fifo.sv
// rtl/sfq_toggle_pulse_rx_fifo.sv - synchronous FIFO of rx_event_t entries (sfq_evt_fifo)
module sfq_evt_fifo
    import sfq_rx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  rx_event_t              data_i,
    input  logic                   pop_i,
    output rx_event_t              data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);

    rx_event_t     mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot a push into a full queue needs.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign level_o = cnt_q;
endmodule

// File: rtl/sfq_toggle_pulse_rx.sv
// rtl/sfq_toggle_pulse_rx.sv - samples a toggle-encoded SFQ line and queues timestamped pulse events
module sfq_toggle_pulse_rx
    import sfq_rx_pkg::*;
#(
    parameter int TS_W       = TS_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int MIN_GAP    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        q_in,
    sfq_toggle_pulse_rx_if.master       ev,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]            pulse_cnt,
    output logic [CNT_W-1:0]            viol_cnt,
    output logic                        overflow
);
    localparam int             GAP_W    = $clog2(MIN_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);

    logic             s1_q, s2_q, prev_q, edge_q, unk_q, s2_unk;
    logic [TS_W-1:0]  ts_q;
    rx_state_e        state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d, viol_cnt_q, viol_cnt_d;
    logic             ovf_q;
    logic             push, push_err, pulse_inc, viol_inc, drop;
    logic             fifo_full, fifo_empty;
    rx_event_t        push_ev, head_ev;
    logic             unused_head;

    assign s2_unk = $isunknown(s2_q);

    // prev only tracks known levels, so the first known sample after X re-baselines it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            edge_q <= 1'b0;
            unk_q  <= 1'b0;
            ts_q   <= '0;
        end else begin
            s1_q   <= q_in;
            s2_q   <= s1_q;
            unk_q  <= s2_unk;
            edge_q <= !s2_unk && (s2_q != prev_q);
            if (!s2_unk) prev_q <= s2_q;
            ts_q   <= ts_q + TS_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        push      = 1'b0;
        push_err  = 1'b0;
        pulse_inc = 1'b0;
        viol_inc  = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                if (unk_q) begin
                    push     = 1'b1;
                    push_err = 1'b1;
                    viol_inc = 1'b1;
                    state_d  = FAULT;
                end else if (edge_q) begin
                    push  = 1'b1;
                    gap_d = GAP_LOAD;
                    if (state_q == IDLE) begin
                        pulse_inc = 1'b1;
                        state_d   = (MIN_GAP > 1) ? GAP : IDLE;
                    end else begin
                        push_err = 1'b1;
                        viol_inc = 1'b1;
                    end
                end else if (state_q == GAP) begin
                    gap_d = gap_q - GAP_W'(1);
                    if (gap_q <= GAP_W'(1)) state_d = IDLE;
                end
            end
            FAULT: begin
                if (!unk_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pulse_cnt_d = pulse_cnt_q;
        viol_cnt_d  = viol_cnt_q;
        if (pulse_inc && (pulse_cnt_q != '1)) pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
        if (viol_inc && (viol_cnt_q != '1))   viol_cnt_d  = viol_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gap_q       <= '0;
            pulse_cnt_q <= '0;
            viol_cnt_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            pulse_cnt_q <= pulse_cnt_d;
            viol_cnt_q  <= viol_cnt_d;
            ovf_q       <= ovf_q | drop;
        end
    end

    always_comb begin
        push_ev     = '0;
        push_ev.ts  = TS_W_DEF'(ts_q);
        push_ev.err = push_err;
    end

    assign drop = push && fifo_full && !(ev.ev_ready && !fifo_empty);

    sfq_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .data_i  (push_ev),
        .pop_i   (ev.ev_ready),
        .data_o  (head_ev),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign ev.ev_valid = !fifo_empty;
    assign ev.ev_ts    = head_ev.ts[TS_W-1:0];
    assign ev.ev_err   = head_ev.err;
    assign unused_head = ^head_ev;

    assign pulse_cnt = pulse_cnt_q;
    assign viol_cnt  = viol_cnt_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_sfq_toggle_pulse_rx.sv
// tb/tb_sfq_toggle_pulse_rx.sv - directed and randomized checks of sfq_toggle_pulse_rx against a sample-level model
module tb_sfq_toggle_pulse_rx;
    localparam int TS_W    = 10;
    localparam int CNT_W   = 4;
    localparam int DEPTH   = 4;
    localparam int MIN_GAP = 2;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int TS_MOD  = 1 << TS_W;

    logic                   clk   = 1'b0;
    logic                   rst   = 1'b1;
    logic                   q_in  = 1'b0;
    logic                   ready = 1'b0;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [CNT_W-1:0]       pulse_cnt;
    logic [CNT_W-1:0]       viol_cnt;
    logic                   overflow;

    sfq_toggle_pulse_rx_if #(.TS_W(TS_W)) ev_if ();
    assign ev_if.ev_ready = ready;

    sfq_toggle_pulse_rx #(
        .TS_W(TS_W), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH), .MIN_GAP(MIN_GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .q_in       (q_in),
        .ev         (ev_if),
        .fifo_level (fifo_level),
        .pulse_cnt  (pulse_cnt),
        .viol_cnt   (viol_cnt),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Model: each line sample at cycle N that is an event lands in the queue at N+3 with ts N+2.
    typedef struct { int at; int ts; bit err; } pend_t;
    pend_t pend[$];
    int    qts[$];
    bit    qerr[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    m_pulse, m_viol, m_last;
    bit    m_ovf, m_prev, m_fault;

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic add_pend(input bit err);
        pend.push_back('{at: cyc + 3, ts: (cyc + 2) % TS_MOD, err: err});
    endtask

    task automatic model_edge();
        pend_t p;
        if (rst) begin
            cyc = 0;
            pend.delete(); qts.delete(); qerr.delete();
            m_pulse = 0; m_viol = 0; m_ovf = 0;
            m_prev = 0; m_fault = 0; m_last = -1000;
        end else begin
            cyc++;
            if (qts.size() != 0 && ready) begin
                void'(qts.pop_front());
                void'(qerr.pop_front());
            end
            while (pend.size() != 0 && pend[0].at == cyc) begin
                p = pend.pop_front();
                if (p.err) m_viol = sat(m_viol);
                else       m_pulse = sat(m_pulse);
                if (qts.size() < DEPTH) begin
                    qts.push_back(p.ts);
                    qerr.push_back(p.err);
                end else begin
                    m_ovf = 1;
                end
            end
            if ($isunknown(q_in)) begin
                if (!m_fault) begin
                    m_fault = 1;
                    add_pend(1);
                end
            end else if (m_fault) begin
                m_fault = 0;
                m_prev  = q_in;
                m_last  = -1000;
            end else if (q_in != m_prev) begin
                m_prev = q_in;
                add_pend((cyc - m_last) < MIN_GAP);
                m_last = cyc;
            end
        end
    endtask

    task automatic check_all();
        check("valid", ev_if.ev_valid, qts.size() != 0);
        check("level", fifo_level, qts.size());
        check("pulse_cnt", pulse_cnt, m_pulse);
        check("viol_cnt", viol_cnt, m_viol);
        check("overflow", overflow, m_ovf);
        if (qts.size() != 0) begin
            check("ev_ts", ev_if.ev_ts, qts[0]);
            check("ev_err", ev_if.ev_err, qerr[0]);
        end
    endtask

    task automatic cycle(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) cycle();
    endtask

    task automatic toggle(input int c);
        run_to(c - 1);
        q_in = ~q_in;
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q_in = 1'b0;
        cycle(3);
        rst = 1'b0;
    endtask

    initial begin
        int r;

        // Reset state and three spaced clean pulses
        do_reset();
        check("rst_valid", ev_if.ev_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_pulse", pulse_cnt, 0);
        check("rst_viol", viol_cnt, 0);
        check("rst_ovf", overflow, 0);
        ready = 1'b1;
        toggle(10);
        run_to(13);
        check("t1_ts0", ev_if.ev_ts, 12);
        check("t1_err0", ev_if.ev_err, 0);
        toggle(20);
        run_to(23);
        check("t1_ts1", ev_if.ev_ts, 22);
        toggle(30);
        run_to(33);
        check("t1_ts2", ev_if.ev_ts, 32);
        run_to(40);
        check("t1_pulse", pulse_cnt, 3);
        check("t1_viol", viol_cnt, 0);

        // Back-to-back toggles: second is a spacing violation
        do_reset();
        toggle(10);
        toggle(11);
        run_to(13);
        check("t2_ts0", ev_if.ev_ts, 12);
        check("t2_err0", ev_if.ev_err, 0);
        run_to(14);
        check("t2_ts1", ev_if.ev_ts, 13);
        check("t2_err1", ev_if.ev_err, 1);
        run_to(20);
        check("t2_pulse", pulse_cnt, 1);
        check("t2_viol", viol_cnt, 1);

        // X on the line, recovery, then a clean pulse
        do_reset();
        run_to(9);
        q_in = 1'bx;
        cycle();
        run_to(14);
        q_in = 1'b0;
        cycle();
        toggle(30);
        run_to(33);
        check("t3_ts", ev_if.ev_ts, 32);
        check("t3_err", ev_if.ev_err, 0);
        check("t3_pulse", pulse_cnt, 1);

        // Overflow with consumer stalled, then in-order drain
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 6; i++) toggle(10 + 5 * i);
        run_to(45);
        check("t4_level", fifo_level, 4);
        check("t4_ovf", overflow, 1);
        check("t4_pulse", pulse_cnt, 6);
        check("t4_ts0", ev_if.ev_ts, 12);
        ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            cycle();
            check("t4_drain", ev_if.ev_ts, 12 + 5 * i);
        end
        cycle();
        check("t4_empty", ev_if.ev_valid, 0);

        // Full queue with push and pop on the same edge
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) toggle(10 + 5 * i);
        run_to(32);
        ready = 1'b1;
        cycle();
        ready = 1'b0;
        check("t5_level", fifo_level, 4);
        check("t5_ovf", overflow, 0);
        check("t5_head", ev_if.ev_ts, 17);
        ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            cycle();
            check("t5_drain", ev_if.ev_ts, 17 + 5 * i);
        end

        // Reset with events queued and edges in flight
        do_reset();
        ready = 1'b0;
        toggle(10);
        toggle(15);
        toggle(20);
        toggle(21);
        check("t6_pre_level", fifo_level, 2);
        rst = 1'b1;
        cycle();
        check("t6_valid", ev_if.ev_valid, 0);
        check("t6_level", fifo_level, 0);
        check("t6_pulse", pulse_cnt, 0);
        check("t6_viol", viol_cnt, 0);
        rst = 1'b0;
        cycle(10);
        check("t6_after_valid", ev_if.ev_valid, 0);
        check("t6_after_pulse", pulse_cnt, 0);

        // Timestamp wrap
        ready = 1'b1;
        toggle(TS_MOD - 3);
        run_to(TS_MOD);
        check("wrap_ts_hi", ev_if.ev_ts, TS_MOD - 1);
        q_in = ~q_in;
        cycle();
        run_to(TS_MOD + 4);
        check("wrap_ts_lo", ev_if.ev_ts, 3);

        // Counter saturation
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 20; i++) toggle(10 + 4 * i);
        run_to(100);
        check("sat_pulse", pulse_cnt, CMAX);

        // Randomized line activity and consumer stalls
        do_reset();
        repeat (600) begin
            ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            if ($isunknown(q_in)) begin
                if (r < 30) q_in = r[0];
            end else if (r < 3) begin
                q_in = 1'bx;
            end else if (r < 18) begin
                q_in = ~q_in;
            end
            cycle();
        end
        if ($isunknown(q_in)) q_in = 1'b0;
        ready = 1'b1;
        cycle(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
